// File: rtl/normalizer_pkg.sv
// Shared definitions for the iterative arithmetic blocks: FSM state encoding
// and a constant-evaluable ceil(log2) helper for sizing count fields.
package normalizer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } norm_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/normalizer.sv
// Iterative leading-bit normalizer: shifts one bit per cycle until the MSB
// (unsigned) or the sign/next-bit pair (signed) marks a normalized value.
module normalizer
  import normalizer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_zero
);

  norm_state_t      state;
  logic [WIDTH-1:0] data;
  logic [CNT_W-1:0] count;
  logic             zero;
  logic             sgn;
  logic             is_zero;
  logic             stop;

  assign is_zero = (data == '0);
  // Signed values are normalized once the top two bits differ.
  assign stop    = sgn ? (data[WIDTH-1] ^ data[WIDTH-2]) : data[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      data  <= '0;
      count <= '0;
      zero  <= 1'b0;
      sgn   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            data  <= in_data;
            sgn   <= sign;
            count <= '0;
            zero  <= 1'b0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (is_zero) begin
            zero  <= 1'b1;
            count <= '0;
            state <= ST_DONE;
          end else if (stop) begin
            state <= ST_DONE;
          end else begin
            data  <= data << 1;
            count <= count + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign out_data  = data;
  assign out_count = count;
  assign out_zero  = zero;

endmodule

// File: tb/tb_normalizer.sv
// Scoreboard bench for normalizer: expectations queued at accept, checked
// (values and latency) when out_valid rises.
module tb_normalizer;
  localparam int W  = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          sign = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;
  logic          out_zero;

  normalizer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .sign(sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  d;
    logic [CW-1:0] c;
    logic          z;
    int            acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic prev_v = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid && !prev_v) begin
      if (sb.size() == 0) chk("unexp_valid", 32'd1, 32'd0);
      else begin
        mon_e = sb.pop_front();
        chk("data",  out_data,  mon_e.d);
        chk("count", out_count, mon_e.c);
        chk("zero",  out_zero,  mon_e.z);
        chk("lat",   cyc - mon_e.acc, mon_e.c + 1);
      end
    end
    prev_v = out_valid;
  end

  // Reference: shift left until normalized, counting shifts.
  task automatic model(input logic [W-1:0] v, input logic s,
                       output logic [W-1:0] d, output logic [CW-1:0] c, output logic z);
    d = v;
    c = '0;
    z = (v == '0);
    if (!z)
      while (s ? (d[W-1] == d[W-2]) : !d[W-1]) begin
        d = d << 1;
        c = c + 1'b1;
      end
  endtask

  task automatic send(input logic [W-1:0] v, input logic s,
                      input logic [W-1:0] ed, input logic [CW-1:0] ec, input logic ez);
    exp_t e;
    int   n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v;
    sign     = s;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_to", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    e.d = ed; e.c = ec; e.z = ez; e.acc = cyc;
    sb.push_back(e);
    in_valid = 1'b0;
    in_data  = W'($urandom);
    sign     = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_to", sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0]  v, ed;
    logic [CW-1:0] ec;
    logic          s, ez;
    int            n;

    #12;
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_zero",  out_zero,  0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready",  in_ready,  1);
    chk("rel_out_valid", out_valid, 0);

    send(8'h87, 1'b0, 8'h87, 3'd0, 1'b0); drain();
    send(8'h07, 1'b0, 8'hE0, 3'd5, 1'b0); drain();
    send(8'hF0, 1'b1, 8'h80, 3'd3, 1'b0); drain();
    send(8'hFF, 1'b1, 8'h80, 3'd7, 1'b0); drain();
    send(8'h00, 1'b0, 8'h00, 3'd0, 1'b1); drain();
    send(8'h00, 1'b1, 8'h00, 3'd0, 1'b1); drain();
    send(8'h01, 1'b1, 8'h40, 3'd6, 1'b0); drain();
    send(8'h40, 1'b1, 8'h40, 3'd0, 1'b0); drain();

    repeat (12) begin
      v = W'($urandom);
      s = 1'($urandom);
      model(v, s, ed, ec, ez);
      send(v, s, ed, ec, ez);
      drain();
    end

    // Backpressure: hold DONE, poke in_valid, then release.
    out_ready = 1'b0;
    send(8'h07, 1'b0, 8'hE0, 3'd5, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach_done", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid",    out_valid, 1);
      chk("bp_data",     out_data,  8'hE0);
      chk("bp_count",    out_count, 5);
      chk("bp_zero",     out_zero,  0);
      chk("bp_in_ready", in_ready,  0);
      in_valid = (i % 2 == 0);
      in_data  = 8'h55;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_valid", out_valid, 0);
    chk("bp_rel_ready", in_ready,  1);
    send(8'h30, 1'b0, 8'hC0, 3'd2, 1'b0); drain();

    // Asynchronous reset mid-shift discards the operation.
    send(8'h01, 1'b0, 8'h80, 3'd7, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_in_ready",  in_ready,  1);
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_count", out_count, 0);
    chk("ar_out_data",  out_data,  0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0 || i == 11) chk("ar_no_valid", out_valid, 0);
    end
    chk("ar_rel_ready", in_ready, 1);
    send(8'h01, 1'b0, 8'h80, 3'd7, 1'b0); drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
